// File: rtl/ac_pkg.sv
// Shared definitions for the air-conditioning sequencer: state encoding and
// default thresholds, also imported by the bench and the display block.
package ac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    REST = 2'd3
  } ac_state_e;

  localparam int DEF_LOW_T   = 18;
  localparam int DEF_HIGH_T  = 22;
  localparam int DEF_MIN_ON  = 8;
  localparam int DEF_MIN_OFF = 4;

  // Hysteresis release point, truncated midpoint of the two thresholds.
  function automatic int mid_temp(input int low_t, input int high_t);
    return (low_t + high_t) / 2;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating dwell counter: cleared on request, otherwise counts up each
// cycle and holds at all-ones.
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    // NOTE: default assigned first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so all flops update from pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ac_sequencer.sv
// Heater/cooler sequencer: hysteresis, minimum run time and an exact rest gap
// between active periods, so the plant never short-cycles or reverses directly.
module ac_sequencer
  import ac_pkg::*;
#(
  parameter int LOW_T   = DEF_LOW_T,
  parameter int HIGH_T  = DEF_HIGH_T,
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] temp,
  input  logic       enable,
  output logic       heating,
  output logic       cooling,
  output logic [1:0] state
);

  localparam int MID = mid_temp(LOW_T, HIGH_T);

  localparam logic [4:0]       LOW_V    = 5'(LOW_T);
  localparam logic [4:0]       HIGH_V   = 5'(HIGH_T);
  localparam logic [4:0]       MID_V    = 5'(MID);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);

  if (LOW_T + 2 > HIGH_T) begin : g_bad_thresholds
    $error("ac_sequencer: LOW_T + 2 must not exceed HIGH_T");
  end
  if (MIN_ON < 1 || MIN_OFF < 1) begin : g_bad_dwell
    $error("ac_sequencer: MIN_ON and MIN_OFF must be at least 1");
  end
  if ((MIN_ON - 1) >= (2 ** CNT_W) || (MIN_OFF - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("ac_sequencer: CNT_W too narrow for MIN_ON/MIN_OFF");
  end

  ac_state_e        state_q;
  ac_state_e        state_d;
  logic             heating_q;
  logic             heating_d;
  logic             cooling_q;
  logic             cooling_d;
  logic [CNT_W-1:0] cnt;
  logic             want_heat;
  logic             want_cool;
  logic             on_done;
  logic             off_done;

  assign want_heat = enable && (temp < LOW_V);
  assign want_cool = enable && (temp > HIGH_V);
  assign on_done   = (cnt >= ON_LAST);
  assign off_done  = (cnt == OFF_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (want_heat)      state_d = HEAT;
        else if (want_cool) state_d = COOL;
      end
      HEAT: begin
        if (!enable)                      state_d = REST;
        else if (on_done && temp >= MID_V) state_d = REST;
      end
      COOL: begin
        if (!enable)                      state_d = REST;
        else if (on_done && temp <= MID_V) state_d = REST;
      end
      REST: begin
        // The rest gap always completes; demand is only re-evaluated on expiry.
        if (off_done) begin
          if (want_heat)      state_d = HEAT;
          else if (want_cool) state_d = COOL;
          else                state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    heating_d = (state_d == HEAT);
    cooling_d = (state_d == COOL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      heating_q <= 1'b0;
      cooling_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      heating_q <= heating_d;
      cooling_q <= cooling_d;
    end
  end

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (state_d != state_q),
    .count (cnt)
  );

  assign heating = heating_q;
  assign cooling = cooling_q;
  assign state   = state_q;

endmodule

// File: tb/tb_ac_sequencer.sv
// Scenario bench for ac_sequencer with a reference-model scoreboard checked
// every cycle alongside the per-scenario expectations.
module tb_ac_sequencer;
  import ac_pkg::*;

  typedef struct packed {
    logic       h;
    logic       c;
    logic [1:0] s;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] temp;
  logic       enable;
  logic       heating;
  logic       cooling;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t      exp_q[$];
  ac_state_e m_state = IDLE;
  int        m_cnt   = 0;

  ac_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .temp    (temp),
    .enable  (enable),
    .heating (heating),
    .cooling (cooling),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: thresholds 18/22, mid 20, run 8, rest 4.
  task automatic model_step(input logic [4:0] t, input logic en, input logic r);
    ac_state_e nxt;
    exp_t      e;
    nxt = m_state;
    if (r) begin
      nxt = IDLE;
    end else begin
      case (m_state)
        IDLE: if (en && t < 18) nxt = HEAT; else if (en && t > 22) nxt = COOL;
        HEAT: if (!en || (m_cnt >= 7 && t >= 20)) nxt = REST;
        COOL: if (!en || (m_cnt >= 7 && t <= 20)) nxt = REST;
        REST: if (m_cnt == 3) begin
          if (en && t < 18)      nxt = HEAT;
          else if (en && t > 22) nxt = COOL;
          else                   nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
    if (r || nxt != m_state) m_cnt = 0;
    else if (m_cnt < 255)    m_cnt = m_cnt + 1;
    m_state = nxt;
    e.h = (nxt == HEAT);
    e.c = (nxt == COOL);
    e.s = nxt;
    exp_q.push_back(e);
  endtask

  // Scoreboard: pops the prediction for each edge and compares just after it.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({heating, cooling, state} !== {e.h, e.c, e.s}) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got h=%b c=%b s=%0d, want h=%b c=%b s=%0d",
                 $time, heating, cooling, state, e.h, e.c, e.s);
      end
    end
  end

  task automatic drive(input logic [4:0] t, input logic en, input logic r);
    @(negedge clk);
    temp   = t;
    enable = en;
    rst    = r;
    model_step(t, en, r);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    drive(5'd15, 1'b1, 1'b1);
    n_checks++;
    if ({heating, cooling, state} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got h=%b c=%b s=%0d, want 0 0 0", heating, cooling, state);
    end
  endtask

  task automatic test_reset_mid_heat();
    drive(5'd15, 1'b1, 1'b0);
    n_checks++;
    if (heating !== 1'b1 || state !== 2'd1) begin
      n_fail++;
      $display("FAIL rmh_enter: got h=%b s=%0d, want h=1 s=1", heating, state);
    end
    drive(5'd15, 1'b1, 1'b1);
    n_checks++;
    if (heating !== 1'b0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL rmh_reset: got h=%b s=%0d, want h=0 s=0", heating, state);
    end
    drive(5'd20, 1'b1, 1'b0);
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL rmh_no_rest: got s=%0d, want s=0", state);
    end
  endtask

  task automatic test_dead_band();
    for (int t = 18; t <= 22; t++) begin
      drive(5'(t), 1'b1, 1'b0);
      n_checks++;
      if ({heating, cooling, state} !== 4'b0000) begin
        n_fail++;
        $display("FAIL dead_band t=%0d: got h=%b c=%b s=%0d, want 0 0 0", t, heating, cooling, state);
      end
    end
  endtask

  task automatic test_hysteresis();
    int on_cycles;
    bit done;
    drive(5'd17, 1'b1, 1'b0);
    n_checks++;
    if (heating !== 1'b1) begin
      n_fail++;
      $display("FAIL hyst_start: got h=%b, want 1", heating);
    end
    on_cycles = 1;
    done      = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      drive(5'd20, 1'b1, 1'b0);
      if (heating === 1'b1) on_cycles++;
      else                  done = 1'b1;
    end
    n_checks++;
    if (on_cycles != 8) begin
      n_fail++;
      $display("FAIL hyst_on_len: got %0d heating cycles, want 8", on_cycles);
    end
    n_checks++;
    if (state !== 2'd3) begin
      n_fail++;
      $display("FAIL hyst_rest_entry: got s=%0d, want 3", state);
    end
    for (int i = 0; i < 3; i++) begin
      drive(5'd20, 1'b1, 1'b0);
      n_checks++;
      if (state !== 2'd3 || heating !== 1'b0) begin
        n_fail++;
        $display("FAIL hyst_rest_%0d: got h=%b s=%0d, want h=0 s=3", i, heating, state);
      end
    end
    drive(5'd20, 1'b1, 1'b0);
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL hyst_idle: got s=%0d, want 0", state);
    end
  endtask

  task automatic test_no_reversal();
    int on_cycles;
    bit done;
    for (int i = 0; i < 8; i++) begin
      drive(5'd15, 1'b1, 1'b0);
      n_checks++;
      if (heating !== 1'b1) begin
        n_fail++;
        $display("FAIL rev_heat_%0d: got h=%b, want 1", i, heating);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(5'd25, 1'b1, 1'b0);
      n_checks++;
      if ({heating, cooling, state} !== 4'b0011) begin
        n_fail++;
        $display("FAIL rev_rest_%0d: got h=%b c=%b s=%0d, want 0 0 3", i, heating, cooling, state);
      end
    end
    drive(5'd25, 1'b1, 1'b0);
    n_checks++;
    if (cooling !== 1'b1 || heating !== 1'b0) begin
      n_fail++;
      $display("FAIL rev_cool_start: got h=%b c=%b, want 0 1", heating, cooling);
    end
    on_cycles = 1;
    done      = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      drive(5'd20, 1'b1, 1'b0);
      if (cooling === 1'b1) on_cycles++;
      else                  done = 1'b1;
    end
    n_checks++;
    if (on_cycles != 8) begin
      n_fail++;
      $display("FAIL rev_cool_len: got %0d cooling cycles, want 8", on_cycles);
    end
    for (int i = 0; i < 3; i++) drive(5'd20, 1'b1, 1'b0);
    drive(5'd20, 1'b1, 1'b0);
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL rev_idle: got s=%0d, want 0", state);
    end
  endtask

  task automatic test_enable_override();
    drive(5'd30, 1'b1, 1'b0);
    drive(5'd30, 1'b1, 1'b0);
    n_checks++;
    if (cooling !== 1'b1) begin
      n_fail++;
      $display("FAIL en_cool: got c=%b, want 1", cooling);
    end
    for (int i = 0; i < 4; i++) begin
      drive(5'd30, 1'b0, 1'b0);
      n_checks++;
      if ({heating, cooling, state} !== 4'b0011) begin
        n_fail++;
        $display("FAIL en_rest_%0d: got h=%b c=%b s=%0d, want 0 0 3", i, heating, cooling, state);
      end
    end
    drive(5'd30, 1'b0, 1'b0);
    n_checks++;
    if ({heating, cooling, state} !== 4'b0000) begin
      n_fail++;
      $display("FAIL en_idle: got h=%b c=%b s=%0d, want 0 0 0", heating, cooling, state);
    end
  endtask

  task automatic test_random();
    logic [4:0] t;
    logic       en;
    logic       r;
    logic       prev_h;
    logic       prev_c;
    int         run_len;
    int         gap_len;
    bit         in_run;
    bit         seen_end;
    bit         gap_rst;
    prev_h   = heating;
    prev_c   = cooling;
    in_run   = 1'b0;
    seen_end = 1'b0;
    gap_rst  = 1'b0;
    run_len  = 0;
    gap_len  = 0;
    for (int i = 0; i < 2000; i++) begin
      t  = 5'($urandom_range(0, 31));
      en = ($urandom_range(0, 7) != 0);
      r  = ($urandom_range(0, 199) == 0);
      drive(t, en, r);
      n_checks++;
      if ((heating && cooling) || (prev_h && cooling) || (prev_c && heating)) begin
        n_fail++;
        $display("FAIL rnd_exclusive cyc=%0d: got h=%b c=%b (prev %b %b), want no overlap or reversal",
                 i, heating, cooling, prev_h, prev_c);
      end
      if (in_run) begin
        if (heating || cooling) begin
          run_len++;
        end else begin
          n_checks++;
          if (run_len < 8 && !r && en) begin
            n_fail++;
            $display("FAIL rnd_run_len cyc=%0d: got %0d, want >= 8", i, run_len);
          end
          in_run   = 1'b0;
          seen_end = 1'b1;
          gap_len  = 1;
          gap_rst  = r;
        end
      end else if (heating || cooling) begin
        if (seen_end) begin
          n_checks++;
          if (gap_len < 4 && !gap_rst) begin
            n_fail++;
            $display("FAIL rnd_gap_len cyc=%0d: got %0d, want >= 4", i, gap_len);
          end
        end
        in_run  = 1'b1;
        run_len = 1;
      end else begin
        gap_len++;
        if (r) gap_rst = 1'b1;
      end
      prev_h = heating;
      prev_c = cooling;
    end
  endtask

  initial begin
    rst    = 1'b1;
    temp   = 5'd20;
    enable = 1'b0;
    test_reset();
    test_reset_mid_heat();
    test_dead_band();
    test_hysteresis();
    test_no_reversal();
    test_enable_override();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
